// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART transmitter
// between up to four byte sources. Each granted byte is framed as an optional
// channel-ID header (8'hA0 | id) followed by the payload byte. The scheduler
// sequences on the transmitter's Tx_BUSY.
//
// Handshake: a source raises req_valid[i] with its byte on req_data and holds
// both until the handshake. req_ready is one-hot and combinational; the byte of
// source i is taken on the rising edge where req_valid[i] & req_ready[i] is high.
module uart_tx_scheduler #(
  parameter int NREQ          = 4,
  parameter bit HEADER_EN     = 1'b1,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        cfg_baud,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        Tx_DATA,
  output logic              Tx_WR,
  output logic              TX_EN,
  output logic [2:0]        baud_select,
  input  logic              Tx_BUSY,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [2:0]        dbg_state
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_HDR     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_WR_DATA    = 3'd4
  } state_t;

  // phase records which byte of the frame is in flight
  localparam logic PH_HDR  = 1'b0;
  localparam logic PH_DATA = 1'b1;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [7:0]    payload_q, payload_d;
  logic [1:0]    gid_q, gid_d;
  logic [1:0]    last_q, last_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wr_q, tx_wr_d;
  logic          tx_en_q;
  logic [2:0]    baud_q, baud_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          win_found;
  logic [1:0]    win_id;
  logic [1:0]    idx;
  logic [7:0]    win_byte;
  logic          hs;
  logic          timeout;

  // Round-robin search starting one past the last granted source
  always_comb begin
    win_found = 1'b0;
    win_id    = last_q;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = 2'((int'(last_q) + off) % NREQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Ready is offered only in IDLE, with the scheduler enabled and the transmitter free
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && en && !Tx_BUSY && win_found) begin
      req_ready = NREQ'(1) << win_id;
    end
  end

  assign hs       = |(req_ready & req_valid);
  assign win_byte = req_data[{win_id, 3'b000} +: 8];

  // Next-state and registered-output logic; Tx_WR is loaded on entry to a WR state
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    payload_d = payload_q;
    gid_d     = gid_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    cnt_d     = cnt_q;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          payload_d = win_byte;
          gid_d     = win_id;
          last_d    = win_id;
          tx_wr_d   = 1'b1;
          if (HEADER_EN) begin
            state_d   = S_WR_HDR;
            tx_data_d = 8'hA0 | {6'b0, win_id};
          end else begin
            state_d   = S_WR_DATA;
            tx_data_d = win_byte;
          end
        end
      end
      S_WR_HDR: begin
        state_d = S_WAIT_START;
        phase_d = PH_HDR;
        cnt_d   = CW'(1);
      end
      S_WR_DATA: begin
        state_d = S_WAIT_START;
        phase_d = PH_DATA;
        cnt_d   = CW'(1);
      end
      S_WAIT_START: begin
        // cnt_q counts cycles elapsed since the WR cycle
        if (Tx_BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        // Tx_DATA is held: the transmitter samples it throughout the byte
        if (!Tx_BUSY) begin
          if (phase_q == PH_HDR) begin
            state_d   = S_WR_DATA;
            tx_data_d = payload_q;
            tx_wr_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear
  always_comb begin
    err_d = err_q;
    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Baud select tracks cfg_baud only while idle so a frame never changes baud
  always_comb begin
    baud_d = baud_q;
    if (state_q == S_IDLE) begin
      baud_d = cfg_baud;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_HDR;
      payload_q <= 8'h00;
      gid_q     <= 2'd0;
      last_q    <= 2'(NREQ - 1);
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      baud_q    <= 3'b000;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      payload_q <= payload_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      tx_en_q   <= en;
      baud_q    <= baud_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Tx_DATA     = tx_data_q;
  assign Tx_WR       = tx_wr_q;
  assign TX_EN       = tx_en_q;
  assign baud_select = baud_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = gid_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a transmitter model answers each
// Tx_WR with 10 busy cycles; a monitor scores every strobe against exp_q.
module tb_uart_tx_scheduler;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;

  logic        clk;
  logic        reset;
  logic        en;
  logic [2:0]  cfg_baud;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  Tx_DATA;
  logic        Tx_WR;
  logic        TX_EN;
  logic [2:0]  baud_select;
  logic        Tx_BUSY;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_timeout;
  logic        err_clr;
  logic [2:0]  dbg_state;

  int          total;
  int          bad;
  int          cyc;
  int          busy_cnt;
  logic        model_on;
  logic        prev_wr;
  logic [7:0]  mon_exp;
  logic [7:0]  exp_q[$];
  int          wr_cyc[$];

  uart_tx_scheduler #(.NREQ(4), .HEADER_EN(1'b1), .START_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_baud    (cfg_baud),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .Tx_DATA     (Tx_DATA),
    .Tx_WR       (Tx_WR),
    .TX_EN       (TX_EN),
    .baud_select (baud_select),
    .Tx_BUSY     (Tx_BUSY),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // transmitter model: busy for 10 cycles after each strobe
  initial begin
    busy_cnt = 0;
    Tx_BUSY  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_cnt > 0) busy_cnt--;
      if (model_on && Tx_WR) busy_cnt = 10;
      Tx_BUSY = (busy_cnt != 0);
    end
  end

  // scoreboard: every strobe must match the head of exp_q and be one cycle wide
  initial begin
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (Tx_WR) begin
        wr_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected: Tx_DATA=%h with nothing expected (cyc %0d)", Tx_DATA, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (Tx_DATA !== mon_exp) begin
            bad++;
            $display("FAIL strobe_data: got %h want %h (cyc %0d)", Tx_DATA, mon_exp, cyc);
          end
        end
        total++;
        if (prev_wr) begin
          bad++;
          $display("FAIL strobe_width: Tx_WR high two cycles (cyc %0d)", cyc);
        end
      end
      prev_wr = Tx_WR;
    end
  end

  // driver tasks
  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    req_data  = '0;
    err_clr   = 1'b0;
    cfg_baud  = 3'b000;
    busy_cnt  = 0;
    exp_q.delete();
    wr_cyc.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // offer byte b on source i; hs = handshake edge number; returns at negedge+1 after it
  task automatic offer(input int i, input logic [7:0] b, output int hs);
    hs = -1;
    req_data[8*i +: 8] = b;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready[i]) begin
        hs = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (hs < 0) begin
      bad++;
      $display("FAIL offer_grant: source %0d never got ready", i);
      req_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (req_ready[i] !== 1'b0) begin
        bad++;
        $display("FAIL ready_one_cycle: req_ready[%0d]=%b want 0 after handshake", i, req_ready[i]);
      end
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit, output int c);
    c = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) begin
        c = cyc;
        break;
      end
    end
    total++;
    if (c < 0) begin
      bad++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, limit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({Tx_WR, Tx_DATA, TX_EN, baud_select, busy, grant_id, err_timeout, dbg_state} !== 20'h0) begin
      bad++;
      $display("FAIL reset_values: wr=%b data=%h txen=%b baud=%b busy=%b gid=%0d err=%b st=%0d want all 0",
               Tx_WR, Tx_DATA, TX_EN, baud_select, busy, grant_id, err_timeout, dbg_state);
    end
    en = 1'b1;
    cfg_baud = 3'b110;
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_priority: req_ready=%b want 0001", req_ready);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (TX_EN !== 1'b1 || baud_select !== 3'b110) begin
      bad++;
      $display("FAIL en_baud_idle: TX_EN=%b baud=%b want 1 110", TX_EN, baud_select);
    end
  endtask

  task automatic test_single_frame();
    int hs;
    int c;
    do_reset();
    model_on = 1'b1;
    en = 1'b1;
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'h5C);
    offer(2, 8'h5C, hs);
    total++;
    if (grant_id !== 2'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: grant_id=%0d busy=%b want 2 1", grant_id, busy);
    end
    wait_idle(60, c);
    total++;
    if (c !== hs + 22) begin
      bad++;
      $display("FAIL single_idle_time: idle at %0d want %0d", c, hs + 22);
    end
    total++;
    if (wr_cyc.size() != 2) begin
      bad++;
      $display("FAIL single_strobes: %0d strobes want 2", wr_cyc.size());
    end else begin
      total++;
      if (wr_cyc[0] != hs || wr_cyc[1] != hs + 11) begin
        bad++;
        $display("FAIL single_strobe_time: at %0d,%0d want %0d,%0d", wr_cyc[0], wr_cyc[1], hs, hs + 11);
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_pending: %0d bytes not sent", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int c;
    logic found;
    do_reset();
    model_on = 1'b1;
    en = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 5; g++) begin
      exp_q.push_back(8'hA0 | 8'(order[g]));
      exp_q.push_back(8'h10 + 8'(order[g]));
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
        #1;
        if (|req_ready) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      total++;
      if (!found || req_ready !== 4'(1 << order[g])) begin
        bad++;
        $display("FAIL rr_order: grant %0d req_ready=%b want %b", g, req_ready, 4'(1 << order[g]));
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 4'b0000;
    wait_idle(60, c);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rr_pending: %0d bytes not sent", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int hs;
    do_reset();
    model_on = 1'b0;
    en = 1'b1;
    exp_q.push_back(8'hA1);
    offer(1, 8'h77, hs);
    repeat (15) @(negedge clk);
    total++;
    if (err_timeout !== 1'b0 || dbg_state !== ST_WAIT_START) begin
      bad++;
      $display("FAIL timeout_early: err=%b st=%0d want 0 %0d at cyc %0d", err_timeout, dbg_state, ST_WAIT_START, cyc);
    end
    @(negedge clk);
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_set: err=%b busy=%b want 1 0 at cyc %0d", err_timeout, busy, cyc);
    end
    repeat (4) @(negedge clk);
    total++;
    if (err_timeout !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_sticky: err=%b pending=%0d want 1 0", err_timeout, exp_q.size());
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: err=%b want 0", err_timeout);
    end
    exp_q.push_back(8'hA2);
    offer(2, 8'h78, hs);
    err_clr = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if (err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout2_early: err=%b want 0", err_timeout);
    end
    @(negedge clk);
    total++;
    if (err_timeout !== 1'b1) begin
      bad++;
      $display("FAIL set_wins_clr: err=%b want 1", err_timeout);
    end
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (err_timeout !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout2_after: err=%b pending=%0d want 1 0", err_timeout, exp_q.size());
    end
  endtask

  task automatic test_baud_freeze();
    int hs;
    int c;
    do_reset();
    model_on = 1'b1;
    en = 1'b1;
    cfg_baud = 3'b001;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h3C);
    offer(0, 8'h3C, hs);
    cfg_baud = 3'b101;
    repeat (5) @(negedge clk);
    total++;
    if (baud_select !== 3'b001) begin
      bad++;
      $display("FAIL baud_mid_frame: baud=%b want 001", baud_select);
    end
    wait_idle(60, c);
    total++;
    if (baud_select !== 3'b001) begin
      bad++;
      $display("FAIL baud_at_idle: baud=%b want 001", baud_select);
    end
    @(negedge clk);
    total++;
    if (baud_select !== 3'b101 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL baud_update: baud=%b pending=%0d want 101 0", baud_select, exp_q.size());
    end
  endtask

  task automatic test_enable();
    int hs;
    int c;
    do_reset();
    model_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h21);
    offer(0, 8'h21, hs);
    en = 1'b0;
    req_data[15:8] = 8'h55;
    req_valid[1] = 1'b1;
    @(negedge clk);
    total++;
    if (TX_EN !== 1'b0) begin
      bad++;
      $display("FAIL txen_follow: TX_EN=%b want 0", TX_EN);
    end
    wait_idle(60, c);
    total++;
    if (c !== hs + 22 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL en_frame_done: idle at %0d pending=%0d want %0d 0", c, exp_q.size(), hs + 22);
    end
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL en_blocks_grant: req_ready=%b busy=%b want 0000 0", req_ready, busy);
    end
    en = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL en_resume: req_ready=%b want 0010", req_ready);
    end
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h55);
    @(posedge clk);
    @(negedge clk);
    #1;
    req_valid = 4'b0000;
    total++;
    if (grant_id !== 2'd1) begin
      bad++;
      $display("FAIL en_grant_id: grant_id=%0d want 1", grant_id);
    end
    wait_idle(60, c);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL en_pending: %0d bytes not sent", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int hs;
    int c;
    logic found;
    do_reset();
    model_on = 1'b1;
    en = 1'b1;
    cfg_baud = 3'b011;
    @(negedge clk);
    exp_q.push_back(8'hA3);
    offer(3, 8'h99, hs);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (dbg_state === ST_WAIT_DONE) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reach_wait_done: state=%0d want %0d", dbg_state, ST_WAIT_DONE);
    end
    reset = 1'b1;
    req_data = {8'h99, 8'h00, 8'h00, 8'h44};
    req_valid = 4'b1001;
    @(negedge clk);
    #1;
    total++;
    if ({Tx_WR, Tx_DATA, TX_EN, baud_select, busy, grant_id, err_timeout, dbg_state} !== 20'h0) begin
      bad++;
      $display("FAIL mid_reset_values: wr=%b data=%h txen=%b baud=%b busy=%b gid=%0d err=%b st=%0d want all 0",
               Tx_WR, Tx_DATA, TX_EN, baud_select, busy, grant_id, err_timeout, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_header: %0d bytes pending want 0", exp_q.size());
    end
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h44);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (|req_ready) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_source0_first: req_ready=%b want 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_idle(60, c);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_pending: %0d bytes not sent", exp_q.size());
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    model_on = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_baud_freeze();
    test_enable();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin transmit scheduler that shares one `uart_transmitter` between up to four byte sources. Each source offers a byte with a valid/ready handshake. The scheduler grants one source at a time and frames the byte as an optional channel-ID header byte followed by the payload byte. It drives the transmitter's `Tx_DATA`, `Tx_WR`, `TX_EN` and `baud_select`, and sequences on its `Tx_BUSY`. It sits between the application sources and the UART transmitter.

## Interface

**Parameters**
- `NREQ`, default 4: number of requesters, legal range 2..4.
- `HEADER_EN`, default 1: 1 sends header byte `8'hA0 | id` before each payload; 0 sends payload only.
- `START_TIMEOUT`, default 16: cycles allowed for `Tx_BUSY` to rise after a `Tx_WR` pulse.

**Ports**
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `en` input 1: scheduler enable; registered and driven onto `TX_EN`.
- `cfg_baud` input 3: baud selection; latched into `baud_select` only in IDLE.
- `req_valid` input NREQ: per-source byte available.
- `req_data` input 8*NREQ: byte of source i at bits [8i+7:8i].
- `req_ready` output NREQ: one-hot, combinational; byte i taken on the edge where `req_valid[i] & req_ready[i]`.
- `Tx_DATA` output 8: byte to transmitter, registered.
- `Tx_WR` output 1: one-cycle write strobe, registered.
- `TX_EN` output 1: transmitter enable, registered copy of `en`.
- `baud_select` output 3: transmitter baud select, registered.
- `Tx_BUSY` input 1: transmitter busy.
- `busy` output 1: high in every state except IDLE.
- `grant_id` output 2: id of the source owning the current frame; holds the last value when idle.
- `err_timeout` output 1: sticky; set when `Tx_BUSY` fails to rise.
- `err_clr` input 1: clears `err_timeout`.

## Operation

**States**

IDLE, WR_HDR, WAIT_START, WAIT_DONE, WR_DATA.

- **IDLE**
  - `req_ready` is the one-hot winner among `req_valid`, searched round-robin starting at `last_grant+1` (wrap at NREQ).
  - Winner is gated by `en` and by `Tx_BUSY==0`; otherwise `req_ready` is all zero.
  - On the handshake edge:
    - capture the payload byte and `grant_id`;
    - set `last_grant = id`;
    - go to WR_HDR if `HEADER_EN`, else WR_DATA.
- **WR_HDR**
  - `Tx_DATA = 8'hA0 | id`, `Tx_WR = 1` for exactly this cycle.
  - Go to WAIT_START with `phase = HDR`.
- **WR_DATA**
  - `Tx_DATA =` payload, `Tx_WR = 1` for one cycle.
  - Go to WAIT_START with `phase = DATA`.
- **WAIT_START**
  - `Tx_WR = 0`; a timeout counter counts cycles.
  - `Tx_BUSY==1`: go to WAIT_DONE.
  - Counter reaches `START_TIMEOUT`: set `err_timeout`, discard the rest of the frame, go to IDLE.
- **WAIT_DONE**
  - `Tx_DATA` is held stable, because the transmitter samples it bit by bit.
  - On `Tx_BUSY==0`:
    - `phase = HDR`: go to WR_DATA;
    - `phase = DATA`: go to IDLE.

**Other rules**
- `baud_select` loads `cfg_baud` every cycle in IDLE and is frozen otherwise, so a frame never changes baud mid-frame.
- `en` falling blocks new grants only; a frame in flight completes. `TX_EN` follows `en` with 1-cycle latency.
- `err_clr` clears `err_timeout` the next edge. If it coincides with a timeout, set wins.
- Round-robin pointer: after reset, `last_grant = NREQ-1`, so source 0 has first priority.

**Reset values**
- IDLE, `Tx_WR 0`, `Tx_DATA 8'h00`, `TX_EN 0`, `baud_select 3'b000`, `busy 0`, `grant_id 0`, `err_timeout 0`.
- Reset mid-frame abandons the frame next edge with no further `Tx_WR`. The transmitter's own reset is handled externally.

## Timing

- **Acceptance:** handshake at edge k; `Tx_WR` high during cycle k+1 (header, or payload if `HEADER_EN=0`).
- **Payload strobe:** the payload `Tx_WR` occurs the cycle after `Tx_BUSY` is sampled low following the header.
- **Back-to-back:** the earliest next-frame handshake is the edge after the final `Tx_BUSY` fall, giving a minimum gap of 2 cycles between the `Tx_BUSY` fall and the next `Tx_WR`.
- **Strobe width:** `Tx_WR` is never high for two consecutive cycles.
- **Timeout:** `err_timeout` asserts exactly `START_TIMEOUT` cycles after the WR state.
- **Ready timing:** `req_ready` is combinational from registered state and `req_valid`. The source must hold `req_valid` and data until the handshake.

## Test plan

- **Single frame:** `HEADER_EN=1`, source 2 sends 8'h5C; transmitter model busy for 10 cycles per byte -> `Tx_DATA` 8'hA2 then 8'h5C, two `Tx_WR` pulses, `busy` low after the second `Tx_BUSY` fall, `req_ready[2]` one cycle.
- **Round robin:** all four `req_valid` held high with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; no source granted twice while others are pending.
- **Timeout:** `Tx_BUSY` tied 0, `START_TIMEOUT=16` -> `err_timeout` set 16 cycles after `Tx_WR`, state returns to IDLE, payload not sent. `err_clr` clears it; simultaneous `err_clr` plus new timeout leaves it set.
- **Baud freeze:** `cfg_baud` changed 3'b001->3'b101 mid-frame -> `baud_select` stays 3'b001 until IDLE, then updates.
- **Enable:** `en` dropped mid-frame -> frame completes; pending `req_valid[1]` not granted until `en` returns.
- **Reset:** `reset` asserted in WAIT_DONE -> all outputs at reset values next edge; after release source 0 wins first.
